button_debounce: RTL



---
 rtl/button_debounce_pkg.sv | 14 +
 rtl/sync_2ff.sv | 25 ++
 rtl/button_debounce.sv | 90 +++++++++
 3 files changed

// File: rtl/button_debounce_pkg.sv
// Shared definitions for the button debouncer:
// FSM state encoding and default debounce width.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_e;

  localparam int unsigned DEF_CNT_BITS = 20;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous board inputs.
// Resets to 0; reusable for buttons and switches.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronizes btn_in, requires a stable
// level for 2^CNT_BITS+1 cycles, then emits level and edge pulses.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned CNT_BITS = DEF_CNT_BITS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE =
    {{(CNT_BITS-1){1'b0}}, 1'b1};

  logic                sync;
  db_state_e           state_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                level_q;
  logic                rise_q;
  logic                fall_q;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (btn_in),
    .q_o   (sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        STABLE_LO: begin
          if (sync) begin
            state_q <= WAIT_HI;
            cnt_q   <= '0;
          end
        end
        WAIT_HI: begin
          // any disagreement restarts the whole wait
          if (!sync) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= STABLE_HI;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!sync) begin
            state_q <= WAIT_LO;
            cnt_q   <= '0;
          end
        end
        WAIT_LO: begin
          if (sync) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= STABLE_LO;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;

endmodule
